vram_access_arbiter: RTL and testbench

//  Shares the single VRAM port (both 8 KB banks) between three requesters: PPU tile fetcher, HDMA/GDMA engine, CPU.

---
 rtl/vram_access_arbiter_pkg.sv | 26 ++
 rtl/vram_access_arbiter_if.sv | 64 ++++++
 rtl/vram_access_arbiter_priority.sv | 28 ++
 rtl/vram_access_arbiter.sv | 138 +++++++++++++
 tb/tb_vram_access_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_access_arbiter_pkg.sv
// Shared types for the VRAM access arbiter: FSM states, owner codes and the
// CPU lock-out predicate used at the grant edge.
package vram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone,
    StDeny
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnPpu,
    OwnDma,
    OwnCpu
  } owner_e;

  localparam logic [1:0] ModeTransfer = 2'd3;

  // VRAM is owned by the PPU pixel transfer while the LCD is on.
  function automatic logic vram_locked(input logic lcd_enable, input logic [1:0] stat_mode);
    return lcd_enable && (stat_mode == ModeTransfer);
  endfunction

endpackage

// File: rtl/vram_access_arbiter_if.sv
// Requester, PPU status and VRAM port signals shared by the arbiter and its
// surroundings; the arbiter uses the slave modport.
interface vram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);

  logic [1:0]        stat_mode;
  logic              lcd_enable;
  logic              vbk_sel;

  logic              ppu_req;
  logic              ppu_bank;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_ack;
  logic [DATA_W-1:0] ppu_rdata;

  logic              dma_req;
  logic              dma_bank;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_denied;
  logic [7:0]        denied_cnt;

  logic              vram_en;
  logic              vram_we;
  logic              vram_bank;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;

  modport master (
    output stat_mode, lcd_enable, vbk_sel,
    output ppu_req, ppu_bank, ppu_addr,
    input  ppu_ack, ppu_rdata,
    output dma_req, dma_bank, dma_addr, dma_wdata,
    input  dma_ack,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_denied, denied_cnt,
    input  vram_en, vram_we, vram_bank, vram_addr, vram_wdata,
    output vram_rdata
  );

  modport slave (
    input  stat_mode, lcd_enable, vbk_sel,
    input  ppu_req, ppu_bank, ppu_addr,
    output ppu_ack, ppu_rdata,
    input  dma_req, dma_bank, dma_addr, dma_wdata,
    output dma_ack,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_denied, denied_cnt,
    output vram_en, vram_we, vram_bank, vram_addr, vram_wdata,
    input  vram_rdata
  );

endinterface

// File: rtl/vram_access_arbiter_priority.sv
// Fixed-priority pick PPU > DMA > CPU. grant is one-hot {cpu, dma, ppu};
// deny flags a CPU request that would have won but VRAM is locked.
module vram_access_arbiter_priority (
  input  logic       ppu_req,
  input  logic       dma_req,
  input  logic       cpu_req,
  input  logic       locked,
  output logic [2:0] grant,
  output logic       deny
);

  always_comb begin
    grant = 3'b000;
    deny  = 1'b0;
    if (ppu_req) begin
      grant[0] = 1'b1;
    end else if (dma_req && !locked) begin
      grant[1] = 1'b1;
    end else if (cpu_req) begin
      if (locked) begin
        deny = 1'b1;
      end else begin
        grant[2] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_access_arbiter.sv
// Shares the single VRAM port between PPU fetch, DMA and CPU. One access per
// three cycles (grant, RAM command, ack); a locked-out CPU access takes two.
module vram_access_arbiter
  import vram_access_arbiter_pkg::*;
#(
  parameter int unsigned         ADDR_W        = 13,
  parameter int unsigned         DATA_W        = 8,
  parameter logic [DATA_W-1:0]   BLOCKED_RDATA = {DATA_W{1'b1}}
) (
  input logic                  clk4_2,
  input logic                  reset,
  vram_access_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [2:0] grant;
  logic       deny;
  logic       locked;

  assign locked = vram_locked(bus.lcd_enable, bus.stat_mode);

  vram_access_arbiter_priority u_priority (
    .ppu_req (bus.ppu_req),
    .dma_req (bus.dma_req),
    .cpu_req (bus.cpu_req),
    .locked  (locked),
    .grant   (grant),
    .deny    (deny)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        unique case (grant)
          3'b001: begin
            state_d = StAccess;
            owner_d = OwnPpu;
            en_d    = 1'b1;
            bank_d  = bus.ppu_bank;
            addr_d  = bus.ppu_addr;
          end
          3'b010: begin
            state_d = StAccess;
            owner_d = OwnDma;
            en_d    = 1'b1;
            we_d    = 1'b1;
            bank_d  = bus.dma_bank;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
          end
          3'b100: begin
            state_d = StAccess;
            owner_d = OwnCpu;
            en_d    = 1'b1;
            we_d    = bus.cpu_we;
            bank_d  = bus.vbk_sel;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
          default: begin
            if (deny) begin
              state_d = StDeny;
              owner_d = OwnCpu;
            end
          end
        endcase
      end
      StAccess: state_d = StDone;
      // No arbitration here so a waiting requester sees the bus free next cycle.
      StDone: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
      StDeny: begin
        state_d = StIdle;
        owner_d = OwnNone;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  always_ff @(posedge clk4_2 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      en_q    <= en_d;
      we_q    <= we_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ppu_ack    = (state_q == StDone) && (owner_q == OwnPpu);
  assign bus.dma_ack    = (state_q == StDone) && (owner_q == OwnDma);
  assign bus.cpu_ack    = ((state_q == StDone) && (owner_q == OwnCpu)) || (state_q == StDeny);
  assign bus.cpu_denied = (state_q == StDeny);
  assign bus.denied_cnt = cnt_q;
  assign bus.ppu_rdata  = bus.vram_rdata;
  assign bus.cpu_rdata  = (state_q == StDeny) ? BLOCKED_RDATA : bus.vram_rdata;

  assign bus.vram_en    = en_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_bank  = bank_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Scoreboard bench for vram_access_arbiter: expected acks are queued when a
// request is issued and checked in order as acks appear.
module tb_vram_access_arbiter;

  logic clk4_2 = 1'b0;
  logic reset;

  always #5 clk4_2 = ~clk4_2;

  vram_access_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  vram_access_arbiter #(
    .ADDR_W        (13),
    .DATA_W        (8),
    .BLOCKED_RDATA (8'hFF)
  ) dut (
    .clk4_2 (clk4_2),
    .reset  (reset),
    .bus    (bus)
  );

  // Two-bank RAM: command sampled at the edge leaving ACCESS, read-before-write.
  logic [7:0] mem [2][8192];
  always @(posedge clk4_2) begin
    if (bus.vram_en) begin
      bus.vram_rdata <= mem[bus.vram_bank][bus.vram_addr];
      if (bus.vram_we) mem[bus.vram_bank][bus.vram_addr] <= bus.vram_wdata;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam logic [2:0] WhoPpu = 3'b001;
  localparam logic [2:0] WhoDma = 3'b010;
  localparam logic [2:0] WhoCpu = 3'b100;

  typedef struct {
    logic [2:0] who;
    logic [7:0] rdata;
    logic       chk_data;
    logic       denied;
  } exp_t;

  exp_t sb[$];

  function automatic void push_exp(input logic [2:0] who, input logic [7:0] rdata,
                                   input logic chk_data, input logic denied);
    exp_t e;
    e.who      = who;
    e.rdata    = rdata;
    e.chk_data = chk_data;
    e.denied   = denied;
    sb.push_back(e);
  endfunction

  always @(negedge clk4_2) begin
    logic [2:0] acks;
    exp_t       e;
    acks = {bus.cpu_ack, bus.dma_ack, bus.ppu_ack};
    if (!reset && acks != 3'b000) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", {29'd0, acks}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("ack_owner", {29'd0, acks}, {29'd0, e.who});
        if (e.chk_data)
          check_eq("rdata", {24'd0, (e.who == WhoPpu) ? bus.ppu_rdata : bus.cpu_rdata},
                   {24'd0, e.rdata});
        check_eq("cpu_denied", {31'd0, bus.cpu_denied}, {31'd0, e.denied});
      end
    end
  end

  task automatic wait_ack(input logic [2:0] who, output int lat);
    logic [2:0] acks;
    lat = 0;
    do begin
      @(negedge clk4_2);
      lat++;
      acks = {bus.cpu_ack, bus.dma_ack, bus.ppu_ack};
    end while ((acks & who) == 3'b000 && lat < 40);
    if ((acks & who) == 3'b000) check_eq("ack_timeout", {29'd0, who}, 32'd0);
  endtask

  task automatic serve_ppu(input logic bank, input logic [12:0] addr, output int lat);
    bus.ppu_bank = bank;
    bus.ppu_addr = addr;
    bus.ppu_req  = 1'b1;
    wait_ack(WhoPpu, lat);
    bus.ppu_req  = 1'b0;
  endtask

  task automatic serve_dma(input logic bank, input logic [12:0] addr, input logic [7:0] wd,
                           output int lat);
    bus.dma_bank  = bank;
    bus.dma_addr  = addr;
    bus.dma_wdata = wd;
    bus.dma_req   = 1'b1;
    wait_ack(WhoDma, lat);
    bus.dma_req   = 1'b0;
  endtask

  task automatic serve_cpu(input logic we, input logic bank, input logic [12:0] addr,
                           input logic [7:0] wd, output int lat);
    bus.vbk_sel   = bank;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_req   = 1'b1;
    wait_ack(WhoCpu, lat);
    bus.cpu_req   = 1'b0;
  endtask

  initial begin
    int l1, l2;
    reset          = 1'b1;
    bus.stat_mode  = 2'd0;
    bus.lcd_enable = 1'b1;
    bus.vbk_sel    = 1'b0;
    bus.ppu_req    = 1'b0;
    bus.ppu_bank   = 1'b0;
    bus.ppu_addr   = '0;
    bus.dma_req    = 1'b0;
    bus.dma_bank   = 1'b0;
    bus.dma_addr   = '0;
    bus.dma_wdata  = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    repeat (3) @(negedge clk4_2);
    check_eq("rst_vram_en", {31'd0, bus.vram_en}, 32'd0);
    check_eq("rst_vram_addr", {19'd0, bus.vram_addr}, 32'd0);
    check_eq("rst_acks", {29'd0, bus.cpu_ack, bus.dma_ack, bus.ppu_ack}, 32'd0);
    check_eq("rst_denied_cnt", {24'd0, bus.denied_cnt}, 32'd0);
    reset = 1'b0;
    @(negedge clk4_2);

    // CPU write to bank 1, then read it back.
    push_exp(WhoCpu, 8'h00, 1'b0, 1'b0);
    fork
      serve_cpu(1'b1, 1'b1, 13'h0123, 8'h5A, l1);
      begin
        @(negedge clk4_2);
        check_eq("acc_en", {31'd0, bus.vram_en}, 32'd1);
        check_eq("acc_we", {31'd0, bus.vram_we}, 32'd1);
        check_eq("acc_bank", {31'd0, bus.vram_bank}, 32'd1);
        check_eq("acc_addr", {19'd0, bus.vram_addr}, 32'h123);
        check_eq("acc_wdata", {24'd0, bus.vram_wdata}, 32'h5A);
      end
    join
    check_eq("cpu_wr_latency", l1, 2);
    @(negedge clk4_2);
    push_exp(WhoCpu, 8'h5A, 1'b1, 1'b0);
    serve_cpu(1'b0, 1'b1, 13'h0123, 8'h00, l1);
    @(negedge clk4_2);

    // Mode 3, LCD on: PPU first, then CPU write is denied and dropped.
    bus.stat_mode = 2'd3;
    push_exp(WhoPpu, 8'h5A, 1'b1, 1'b0);
    push_exp(WhoCpu, 8'hFF, 1'b1, 1'b1);
    fork
      serve_ppu(1'b1, 13'h0123, l1);
      serve_cpu(1'b1, 1'b1, 13'h0123, 8'h11, l2);
    join
    check_eq("ppu_latency", l1, 2);
    check_eq("deny_latency", l2, 4);
    @(negedge clk4_2);
    check_eq("denied_cnt_1", {24'd0, bus.denied_cnt}, 32'd1);

    // Same with LCD off: CPU reaches RAM and sees data unchanged by the denied write.
    bus.lcd_enable = 1'b0;
    push_exp(WhoPpu, 8'h5A, 1'b1, 1'b0);
    push_exp(WhoCpu, 8'h5A, 1'b1, 1'b0);
    fork
      serve_ppu(1'b1, 13'h0123, l1);
      serve_cpu(1'b0, 1'b1, 13'h0123, 8'h00, l2);
    join
    check_eq("cpu_after_ppu_latency", l2, 5);
    @(negedge clk4_2);
    check_eq("denied_cnt_lcd_off", {24'd0, bus.denied_cnt}, 32'd1);

    // VBlank: DMA write then CPU read of the same byte, acks three cycles apart.
    bus.lcd_enable = 1'b1;
    bus.stat_mode  = 2'd1;
    push_exp(WhoDma, 8'h00, 1'b0, 1'b0);
    push_exp(WhoCpu, 8'hC3, 1'b1, 1'b0);
    fork
      serve_dma(1'b0, 13'h0456, 8'hC3, l1);
      serve_cpu(1'b0, 1'b0, 13'h0456, 8'h00, l2);
    join
    check_eq("dma_latency", l1, 2);
    check_eq("dma_cpu_spacing", l2 - l1, 3);
    @(negedge clk4_2);

    // DMA held off during mode 3 until the mode changes.
    bus.stat_mode = 2'd3;
    push_exp(WhoDma, 8'h00, 1'b0, 1'b0);
    fork
      serve_dma(1'b0, 13'h0457, 8'h3C, l1);
      begin
        repeat (6) @(negedge clk4_2);
        check_eq("dma_held_off", {31'd0, bus.vram_en}, 32'd0);
        bus.stat_mode = 2'd0;
      end
    join
    check_eq("dma_release_latency", l1, 8);
    @(negedge clk4_2);
    push_exp(WhoPpu, 8'h3C, 1'b1, 1'b0);
    serve_ppu(1'b0, 13'h0457, l1);
    @(negedge clk4_2);

    // 256 blocked CPU reads: counter saturates.
    bus.stat_mode = 2'd3;
    for (int i = 0; i < 256; i++) begin
      push_exp(WhoCpu, 8'hFF, 1'b1, 1'b1);
      serve_cpu(1'b0, 1'b0, 13'(i), 8'h00, l1);
      if (i == 0) check_eq("deny_alone_latency", l1, 1);
      @(negedge clk4_2);
      if (i == 99) check_eq("denied_cnt_101", {24'd0, bus.denied_cnt}, 32'd101);
    end
    check_eq("denied_cnt_sat", {24'd0, bus.denied_cnt}, 32'd255);

    // Mode turns 3 after the grant: access still completes.
    bus.stat_mode = 2'd0;
    push_exp(WhoCpu, 8'hC3, 1'b1, 1'b0);
    fork
      serve_cpu(1'b0, 1'b0, 13'h0456, 8'h00, l1);
      begin
        @(negedge clk4_2);
        bus.stat_mode = 2'd3;
      end
    join
    check_eq("late_mode3_latency", l1, 2);
    @(negedge clk4_2);
    check_eq("denied_cnt_still_sat", {24'd0, bus.denied_cnt}, 32'd255);

    // Reset in the middle of an access: no ack, everything back to reset values.
    bus.stat_mode = 2'd0;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 13'h0010;
    bus.cpu_wdata = 8'h77;
    bus.cpu_req   = 1'b1;
    @(negedge clk4_2);
    check_eq("pre_reset_en", {31'd0, bus.vram_en}, 32'd1);
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk4_2);
    check_eq("mid_reset_en", {31'd0, bus.vram_en}, 32'd0);
    check_eq("mid_reset_acks", {29'd0, bus.cpu_ack, bus.dma_ack, bus.ppu_ack}, 32'd0);
    check_eq("mid_reset_denied_cnt", {24'd0, bus.denied_cnt}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk4_2);
    check_eq("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
